// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed loads/stores into word-aligned memory beats,
// splitting word-crossing accesses and merging sub-word stores by read-modify-write.
module load_store_unit #(
  parameter int ALLOW_MISALIGNED = 1,
  parameter int ADDR_W           = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [4:0]        rd_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       mem_wdata_o,
  output logic              mem_we_o,
  output logic              resp_valid_o,
  output logic [31:0]       resp_data_o,
  output logic [4:0]        resp_rd_o,
  output logic              resp_err_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD0  = 3'd1;
  localparam logic [2:0] S_RD1  = 3'd2;
  localparam logic [2:0] S_WR0  = 3'd3;
  localparam logic [2:0] S_WR1  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic              r_store;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic              r_cross;
  logic              r_err;
  logic [ADDR_W-1:0] r_a0;
  logic [31:0]       r_wdata;
  logic [4:0]        r_rd;
  logic [31:0]       r_buf0;
  logic [31:0]       r_buf1;

  logic              w_accept;
  logic [2:0]        w_req_size;
  logic              w_req_cross;
  logic              w_req_illegal;
  logic              w_req_err;
  logic              w_req_sw_aligned;
  logic [ADDR_W-1:0] w_a1;
  logic [4:0]        w_shamt;
  logic [63:0]       w_size_mask;
  logic [63:0]       w_mask;
  logic [63:0]       w_merged;
  logic [31:0]       w_shifted;
  logic [31:0]       w_load;

  assign req_ready_o = (r_state == S_IDLE) && !reset;
  assign w_accept    = req_valid_i && req_ready_o;

  always_comb begin
    case (funct3_i[1:0])
      2'b00:   w_req_size = 3'd1;
      2'b01:   w_req_size = 3'd2;
      default: w_req_size = 3'd4;
    endcase
  end

  assign w_req_cross      = ({1'b0, addr_i[1:0]} + w_req_size) > 3'd4;
  assign w_req_illegal    = req_store_i ? (funct3_i > 3'b010)
                                        : ((funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11));
  assign w_req_err        = w_req_illegal || (w_req_cross && (ALLOW_MISALIGNED == 0));
  assign w_req_sw_aligned = req_store_i && (funct3_i == 3'b010) && (addr_i[1:0] == 2'b00);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err)             w_next = S_DONE;
          else if (w_req_sw_aligned) w_next = S_WR0;
          else                       w_next = S_RD0;
        end
      end
      S_RD0:   w_next = r_cross ? S_RD1 : (r_store ? S_WR0 : S_DONE);
      S_RD1:   w_next = r_store ? S_WR0 : S_DONE;
      S_WR0:   w_next = r_cross ? S_WR1 : S_DONE;
      S_WR1:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_store <= 1'b0;
      r_f3    <= 3'b000;
      r_off   <= 2'b00;
      r_cross <= 1'b0;
      r_err   <= 1'b0;
      r_a0    <= '0;
      r_wdata <= 32'h0;
      r_rd    <= 5'h0;
      r_buf0  <= 32'h0;
      r_buf1  <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_store <= req_store_i;
        r_f3    <= funct3_i;
        r_off   <= addr_i[1:0];
        r_cross <= w_req_cross;
        r_err   <= w_req_err;
        r_a0    <= {addr_i[ADDR_W-1:2], 2'b00};
        r_wdata <= wdata_i;
        r_rd    <= rd_i;
        r_buf0  <= 32'h0;
        r_buf1  <= 32'h0;
      end
      if (r_state == S_RD0) r_buf0 <= mem_rdata_i;
      if (r_state == S_RD1) r_buf1 <= mem_rdata_i;
    end
  end

  // Second word address wraps naturally at the top of the address space.
  assign w_a1    = r_a0 + {{(ADDR_W-3){1'b0}}, 3'b100};
  assign w_shamt = {r_off, 3'b000};

  always_comb begin
    case (r_f3[1:0])
      2'b00:   w_size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   w_size_mask = 64'h0000_0000_0000_FFFF;
      default: w_size_mask = 64'h0000_0000_FFFF_FFFF;
    endcase
  end

  assign w_mask    = w_size_mask << w_shamt;
  assign w_merged  = ({r_buf1, r_buf0} & ~w_mask) | (({32'h0, r_wdata} << w_shamt) & w_mask);
  assign w_shifted = 32'({r_buf1, r_buf0} >> w_shamt);

  always_comb begin
    case (r_f3)
      3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_load = w_shifted;
      3'b100:  w_load = {24'h0, w_shifted[7:0]};
      3'b101:  w_load = {16'h0, w_shifted[15:0]};
      default: w_load = 32'h0;
    endcase
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0;
    case (r_state)
      S_RD0: mem_addr_o = r_a0;
      S_RD1: mem_addr_o = w_a1;
      S_WR0: begin
        mem_addr_o  = r_a0;
        mem_wdata_o = w_merged[31:0];
      end
      S_WR1: begin
        mem_addr_o  = w_a1;
        mem_wdata_o = w_merged[63:32];
      end
      default: ;
    endcase
  end

  assign mem_we_o     = ((r_state == S_WR0) || (r_state == S_WR1)) && !reset;
  assign resp_valid_o = (r_state == S_DONE);
  assign resp_err_o   = (r_state == S_DONE) && r_err;
  assign resp_rd_o    = (r_state == S_DONE) ? r_rd : 5'h0;
  assign resp_data_o  = ((r_state == S_DONE) && !r_err && !r_store) ? w_load : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a small word memory model, a split-enabled
// instance for the main traffic and a split-disabled instance for the misalign error.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [4:0]  rd;
  logic [31:0] mem_addr, mem_rdata, mem_wdata;
  logic        mem_we;
  logic        resp_valid, resp_err;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;

  logic        v1, x_ready, x_we, x_valid, x_err;
  logic [2:0]  f1;
  logic [31:0] a1, x_addr, x_wdata, x_data;
  logic [4:0]  x_rd;

  logic [31:0] mem [0:15];
  logic        load_mem;
  int          wr_cnt;

  int          n_chk = 0;
  int          n_err = 0;
  int          lat, nwr;
  logic [31:0] r_data;
  logic        r_err_s, ready_after;
  logic [4:0]  r_rd_s;
  logic [31:0] alog  [0:15];
  logic        welog [0:15];
  logic [31:0] wdlog [0:15];

  always #5 clk = ~clk;

  load_store_unit #(.ALLOW_MISALIGNED(1), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_store_i(req_store), .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
    .rd_i(rd), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata), .mem_wdata_o(mem_wdata),
    .mem_we_o(mem_we), .resp_valid_o(resp_valid), .resp_data_o(resp_data),
    .resp_rd_o(resp_rd), .resp_err_o(resp_err)
  );

  load_store_unit #(.ALLOW_MISALIGNED(0), .ADDR_W(32)) dut_nomis (
    .clk(clk), .reset(reset), .req_valid_i(v1), .req_ready_o(x_ready),
    .req_store_i(1'b0), .funct3_i(f1), .addr_i(a1), .wdata_i(32'h0),
    .rd_i(5'd9), .mem_addr_o(x_addr), .mem_rdata_i(32'h12345678), .mem_wdata_o(x_wdata),
    .mem_we_o(x_we), .resp_valid_o(x_valid), .resp_data_o(x_data),
    .resp_rd_o(x_rd), .resp_err_o(x_err)
  );

  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0]  <= 32'h44332211;
      mem[1]  <= 32'h88776655;
      mem[15] <= 32'hA5B6C7D8;
      wr_cnt  <= 0;
    end else if (mem_we) begin
      mem[mem_addr[5:2]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One transaction on the main instance; records per-cycle memory activity
  // from T+1 until the response (bounded at 10 cycles) plus one cycle after.
  task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [4:0] r);
    int wr0;
    @(negedge clk);
    req_valid = 1'b1; req_store = st; funct3 = f3; addr = a; wdata = wd; rd = r;
    #1 chk("ready_before_accept", {31'h0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wr0 = wr_cnt;
    lat = 0; r_data = 32'hDEADDEAD; r_err_s = 1'bx; r_rd_s = 5'h1F;
    for (int i = 0; i < 16; i++) begin alog[i] = 32'hX; welog[i] = 1'bx; wdlog[i] = 32'hX; end
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk); #1;
      alog[k] = mem_addr; welog[k] = mem_we; wdlog[k] = mem_wdata;
      if (resp_valid) begin
        lat = k; r_data = resp_data; r_err_s = resp_err; r_rd_s = resp_rd;
      end
    end
    @(negedge clk); #1;
    ready_after = req_ready;
    chk("resp_pulse_one_cycle", {31'h0, resp_valid}, 32'd0);
    nwr = wr_cnt - wr0;
  endtask

  initial begin
    reset = 1'b1; load_mem = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0; rd = 5'h0;
    v1 = 1'b0; f1 = 3'b000; a1 = 32'h0;
    @(negedge clk); #1;
    chk("rst_ready", {31'h0, req_ready}, 32'd0);
    chk("rst_we", {31'h0, mem_we}, 32'd0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    @(negedge clk);
    reset = 1'b0; load_mem = 1'b0;
    #1 chk("ready_after_reset", {31'h0, req_ready}, 32'd1);

    txn(1'b0, 3'b010, 32'h100, 32'h0, 5'd5);
    chk("lw_lat", lat, 2);
    chk("lw_data", r_data, 32'h44332211);
    chk("lw_rd", {27'h0, r_rd_s}, 32'd5);
    chk("lw_err", {31'h0, r_err_s}, 32'd0);
    chk("lw_addr", alog[1], 32'h100);
    chk("lw_no_we", {31'h0, welog[1]}, 32'd0);
    chk("lw_nwr", nwr, 0);
    chk("lw_ready_after", {31'h0, ready_after}, 32'd1);

    txn(1'b0, 3'b000, 32'h107, 32'h0, 5'd1);
    chk("lb_data", r_data, 32'hFFFFFF88);
    chk("lb_lat", lat, 2);
    txn(1'b0, 3'b100, 32'h107, 32'h0, 5'd2);
    chk("lbu_data", r_data, 32'h00000088);
    txn(1'b0, 3'b001, 32'h106, 32'h0, 5'd3);
    chk("lh_data", r_data, 32'hFFFF8877);

    txn(1'b0, 3'b010, 32'h102, 32'h0, 5'd3);
    chk("lw_x_lat", lat, 3);
    chk("lw_x_addr0", alog[1], 32'h100);
    chk("lw_x_addr1", alog[2], 32'h104);
    chk("lw_x_data", r_data, 32'h66554433);

    txn(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 5'd4);
    chk("wrap_lat", lat, 3);
    chk("wrap_addr0", alog[1], 32'hFFFFFFFC);
    chk("wrap_addr1", alog[2], 32'h00000000);
    chk("wrap_data", r_data, 32'h2211A5B6);

    txn(1'b1, 3'b001, 32'h103, 32'h0000BEEF, 5'd12);
    chk("sh_x_lat", lat, 5);
    chk("sh_x_rd", {27'h0, r_rd_s}, 32'd12);
    chk("sh_x_resp_data", r_data, 32'h0);
    chk("sh_x_wr0_addr", alog[3], 32'h100);
    chk("sh_x_wr0_we", {31'h0, welog[3]}, 32'd1);
    chk("sh_x_wr0_data", wdlog[3], 32'hEF332211);
    chk("sh_x_wr1_addr", alog[4], 32'h104);
    chk("sh_x_wr1_data", wdlog[4], 32'h887766BE);
    chk("sh_x_rd_no_we", {31'h0, welog[1] | welog[2]}, 32'd0);
    chk("sh_x_nwr", nwr, 2);
    chk("sh_x_mem0", mem[0], 32'hEF332211);
    chk("sh_x_mem1", mem[1], 32'h887766BE);

    txn(1'b0, 3'b001, 32'h103, 32'h0, 5'd6);
    chk("lh_x_data", r_data, 32'hFFFFBEEF);
    chk("lh_x_lat", lat, 3);

    txn(1'b1, 3'b000, 32'h101, 32'hFFFFFF5A, 5'd7);
    chk("sb_lat", lat, 3);
    chk("sb_nwr", nwr, 1);
    chk("sb_mem0", mem[0], 32'hEF335A11);

    txn(1'b1, 3'b010, 32'h104, 32'hCAFEBABE, 5'd8);
    chk("sw_lat", lat, 2);
    chk("sw_addr", alog[1], 32'h104);
    chk("sw_we", {31'h0, welog[1]}, 32'd1);
    chk("sw_nwr", nwr, 1);
    chk("sw_mem1", mem[1], 32'hCAFEBABE);

    txn(1'b0, 3'b100, 32'h105, 32'h0, 5'd9);
    chk("lbu2_data", r_data, 32'h000000BA);
    txn(1'b0, 3'b101, 32'h106, 32'h0, 5'd10);
    chk("lhu_data", r_data, 32'h0000CAFE);

    txn(1'b0, 3'b011, 32'h100, 32'h0, 5'd11);
    chk("ill_ld_lat", lat, 1);
    chk("ill_ld_err", {31'h0, r_err_s}, 32'd1);
    chk("ill_ld_data", r_data, 32'h0);
    chk("ill_ld_rd", {27'h0, r_rd_s}, 32'd11);
    chk("ill_ld_no_access", alog[1], 32'h0);
    chk("ill_ld_ready_t2", {31'h0, ready_after}, 32'd1);
    txn(1'b0, 3'b110, 32'h100, 32'h0, 5'd13);
    chk("ill_ld110_err", {31'h0, r_err_s}, 32'd1);
    txn(1'b1, 3'b011, 32'h100, 32'h11111111, 5'd14);
    chk("ill_st_lat", lat, 1);
    chk("ill_st_err", {31'h0, r_err_s}, 32'd1);
    chk("ill_st_nwr", nwr, 0);

    // Reset during WR0 of a crossing halfword store.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; funct3 = 3'b001; addr = 32'h103; wdata = 32'h00001234; rd = 5'd15;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mid_in_wr0_we", {31'h0, mem_we}, 32'd1);
    chk("rst_mid_in_wr0_addr", mem_addr, 32'h100);
    reset = 1'b1;
    #1;
    chk("rst_mid_we_drop", {31'h0, mem_we}, 32'd0);
    chk("rst_mid_ready", {31'h0, req_ready}, 32'd0);
    chk("rst_mid_no_resp", {31'h0, resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    #1 chk("rst_mid_no_resp_held", {31'h0, resp_valid}, 32'd0);
    reset = 1'b0;
    #1 chk("rst_mid_ready_release", {31'h0, req_ready}, 32'd1);
    chk("rst_mid_mem0", mem[0], 32'hEF335A11);
    chk("rst_mid_mem1", mem[1], 32'hCAFEBABE);

    txn(1'b0, 3'b010, 32'h100, 32'h0, 5'd16);
    chk("post_rst_lw", r_data, 32'hEF335A11);

    // Split-disabled instance: crossing load is an error with no memory access.
    @(negedge clk);
    v1 = 1'b1; f1 = 3'b010; a1 = 32'h102;
    #1 chk("nomis_ready", {31'h0, x_ready}, 32'd1);
    @(posedge clk);
    #1 v1 = 1'b0;
    @(negedge clk); #1;
    chk("nomis_err_valid", {31'h0, x_valid}, 32'd1);
    chk("nomis_err", {31'h0, x_err}, 32'd1);
    chk("nomis_err_data", x_data, 32'h0);
    chk("nomis_rd", {27'h0, x_rd}, 32'd9);
    chk("nomis_no_read", x_addr, 32'h0);
    @(negedge clk); #1;
    chk("nomis_ready_again", {31'h0, x_ready}, 32'd1);
    v1 = 1'b1; f1 = 3'b010; a1 = 32'h100;
    @(posedge clk);
    #1 v1 = 1'b0;
    @(negedge clk); #1;
    chk("nomis_lw_addr", x_addr, 32'h100);
    chk("nomis_lw_t1_no_resp", {31'h0, x_valid}, 32'd0);
    @(negedge clk); #1;
    chk("nomis_lw_valid", {31'h0, x_valid}, 32'd1);
    chk("nomis_lw_data", x_data, 32'h12345678);
    chk("nomis_lw_no_err", {31'h0, x_err}, 32'd0);
    chk("nomis_no_we", {31'h0, x_we}, 32'd0);
    chk("nomis_wdata_idle", x_wdata, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
